id_stage_p: RTL and testbench

- Parametrised successor to the 16-bit decode stage of the pipelined RISC core.
- Decodes 16-bit instructions and holds an XLEN-wide, 8-entry register file with writeback bypass.
- Detects load-use hazards internally and registers all decode results into an ID/EX pipeline register with valid, stall and flush control.
- Sits between the IF/ID register and the EX stage.

---
 rtl/id_stage_p_pkg.sv | 85 ++++++++
 rtl/id_regfile.sv | 60 ++++++
 rtl/id_stage_p.sv | 261 ++++++++++++++++++++++++++
 tb/tb_id_stage_p.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_p_pkg.sv
// Shared definitions for the ID stage: opcode values, ALU operation codes,
// instruction field positions, the link register index, the ID/EX control
// bundle type and small opcode-classification helpers.
package id_stage_p_pkg;

  // Major opcodes, instruction[15:12]
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_J     = 4'h6;
  localparam logic [3:0] OP_JAL   = 4'h7;
  localparam logic [3:0] OP_JR    = 4'h8;
  localparam logic [3:0] OP_ANDI  = 4'h9;
  localparam logic [3:0] OP_ORI   = 4'hA;
  localparam logic [3:0] OP_SLTI  = 4'hB;
  // Opcodes at or above this value are illegal
  localparam logic [3:0] OP_ILL_MIN = 4'hC;

  // ALU operations; R-type uses {1'b0, funct} so these match funct values
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;
  localparam logic [3:0] ALU_SLL = 4'h6;
  localparam logic [3:0] ALU_SRL = 4'h7;

  localparam logic [2:0] LINK_REG = 3'd7;

  // Instruction field bit positions
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RS_HI    = 11;
  localparam int RS_LO    = 9;
  localparam int RT_HI    = 8;
  localparam int RT_LO    = 6;
  localparam int RD_HI    = 5;
  localparam int RD_LO    = 3;
  localparam int FUNCT_HI = 2;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 5;
  localparam int IMM_LO   = 0;
  localparam int IMM_W    = IMM_HI - IMM_LO + 1;

  // Control bundle carried in the ID/EX register
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jump_reg;
    logic       link;
  } ctrl_t;

  // True when the opcode reads the rs field as a source operand
  function automatic logic uses_rs(input logic [3:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_JR, OP_ANDI, OP_ORI, OP_SLTI: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

  // True when the opcode reads the rt field as a source operand
  function automatic logic uses_rt(input logic [3:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: r = 1'b1;
      default:                         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 8-entry register file for the ID stage.
// Two combinational read ports, one synchronous write port. r0 always reads
// zero and ignores writes. With WB_BYPASS=1 a read of the register being
// written in the same cycle returns the incoming write data.
// Ports:
//   clk, rst_n         clock, async active-low reset (clears all entries)
//   raddr1/raddr2      read addresses
//   rdata1/rdata2      read data
//   we, waddr, wdata   write enable, address, data
module id_regfile #(
  parameter int XLEN      = 16,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      raddr1,
  input  logic [2:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [2:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem_r [8];

  // Storage: cleared on reset, written on the clock edge except for r0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && (waddr != 3'd0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port 1 with r0 forcing and optional writeback forwarding
  always_comb begin
    if (raddr1 == 3'd0) begin
      rdata1 = '0;
    end else if ((WB_BYPASS != 0) && we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = mem_r[raddr1];
    end
  end

  // Read port 2 with r0 forcing and optional writeback forwarding
  always_comb begin
    if (raddr2 == 3'd0) begin
      rdata2 = '0;
    end else if ((WB_BYPASS != 0) && we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = mem_r[raddr2];
    end
  end

endmodule

// File: rtl/id_stage_p.sv
// Instruction decode stage with ID/EX pipeline register.
// Decodes a 16-bit instruction, reads operands from id_regfile, detects
// load-use hazards against the instruction currently in ID/EX and registers
// the results. Priority at each edge: flush (bubble) > stall (hold) >
// hazard (bubble) > decode. instr_valid=0 also loads a bubble.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   stall, flush                     hold / kill control for ID/EX
//   instr_valid, instruction, pc     incoming instruction from IF/ID
//   wb_reg_write/_write_reg/_data    register file writeback
//   hazard_stall                     combinational load-use stall request
//   ex_*                             registered decode results
// Optional build macro ID_ILLEGAL_TRAP_EN adds output ex_illegal, set with
// ex_valid for opcodes C-F; without it those opcodes decode as a plain NOP.
module id_stage_p
  import id_stage_p_pkg::*;
#(
  parameter int XLEN          = 16,
  parameter int WB_BYPASS     = 1,
  parameter int HAZARD_DETECT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            instr_valid,
  input  logic [15:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_reg_write,
  input  logic [2:0]      wb_write_reg,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [2:0]      ex_rs,
  output logic [2:0]      ex_rt,
  output logic [2:0]      ex_dest,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_reg1_data,
  output logic [XLEN-1:0] ex_reg2_data,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_alu_src,
  output logic [3:0]      ex_alu_op,
  output logic            ex_branch,
  output logic            ex_branch_ne,
  output logic            ex_jump,
  output logic            ex_jump_reg,
  output logic            ex_link
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic            ex_illegal
`endif
);

  // Instruction fields
  logic [3:0]      op_s;
  logic [2:0]      rs_s;
  logic [2:0]      rt_s;
  logic [2:0]      rd_s;
  logic [2:0]      funct_s;
  logic [IMM_W-1:0] imm6_s;

  assign op_s    = instruction[OP_HI:OP_LO];
  assign rs_s    = instruction[RS_HI:RS_LO];
  assign rt_s    = instruction[RT_HI:RT_LO];
  assign rd_s    = instruction[RD_HI:RD_LO];
  assign funct_s = instruction[FUNCT_HI:FUNCT_LO];
  assign imm6_s  = instruction[IMM_HI:IMM_LO];

  // Operand read
  logic [XLEN-1:0] rdata1_s;
  logic [XLEN-1:0] rdata2_s;

  id_regfile #(
    .XLEN      (XLEN),
    .WB_BYPASS (WB_BYPASS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs_s),
    .raddr2 (rt_s),
    .rdata1 (rdata1_s),
    .rdata2 (rdata2_s),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg),
    .wdata  (wb_write_data)
  );

  // ID/EX register state
  logic            ex_valid_r;
  logic [XLEN-1:0] ex_pc_r;
  logic [2:0]      ex_rs_r;
  logic [2:0]      ex_rt_r;
  logic [2:0]      ex_dest_r;
  logic [XLEN-1:0] ex_imm_r;
  logic [XLEN-1:0] ex_reg1_r;
  logic [XLEN-1:0] ex_reg2_r;
  ctrl_t           ex_ctrl_r;

  // Decode results
  ctrl_t           ctrl_s;
  logic [2:0]      dest_s;
  logic [XLEN-1:0] imm_s;

  // Opcode decode into controls, destination and immediate
  always_comb begin
    ctrl_s = '0;
    dest_s = 3'd0;
    imm_s  = {{(XLEN-IMM_W){imm6_s[IMM_W-1]}}, imm6_s};
    case (op_s)
      OP_RTYPE: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_op    = {1'b0, funct_s};
        dest_s           = rd_s;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        dest_s           = rt_s;
        if (op_s == OP_ANDI) begin
          ctrl_s.alu_op = ALU_AND;
          imm_s         = {{(XLEN-IMM_W){1'b0}}, imm6_s};
        end else if (op_s == OP_ORI) begin
          ctrl_s.alu_op = ALU_OR;
          imm_s         = {{(XLEN-IMM_W){1'b0}}, imm6_s};
        end else if (op_s == OP_SLTI) begin
          ctrl_s.alu_op = ALU_SLT;
        end else begin
          ctrl_s.alu_op = ALU_ADD;
        end
      end
      OP_LW: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_read   = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.alu_src    = 1'b1;
        ctrl_s.alu_op     = ALU_ADD;
        dest_s            = rt_s;
      end
      OP_SW: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_s.branch = 1'b1;
        ctrl_s.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_s.branch_ne = 1'b1;
        ctrl_s.alu_op    = ALU_SUB;
      end
      OP_J: begin
        ctrl_s.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl_s.jump      = 1'b1;
        ctrl_s.link      = 1'b1;
        ctrl_s.reg_write = 1'b1;
        dest_s           = LINK_REG;
      end
      OP_JR: begin
        ctrl_s.jump_reg = 1'b1;
      end
      default: begin
        // Illegal opcodes: valid NOP with no controls
        dest_s = 3'd0;
      end
    endcase
  end

  // Load-use hazard: the load in ID/EX targets a source of the incoming op
  logic hazard_s;
  assign hazard_s = (HAZARD_DETECT != 0) && instr_valid && ex_valid_r &&
                    ex_ctrl_r.mem_read && (ex_dest_r != 3'd0) &&
                    ((uses_rs(op_s) && (rs_s == ex_dest_r)) ||
                     (uses_rt(op_s) && (rt_s == ex_dest_r)));

  logic bubble_s;
  assign bubble_s = flush || (!stall && (hazard_s || !instr_valid));

`ifdef ID_ILLEGAL_TRAP_EN
  logic ex_illegal_r;
  logic illegal_s;
  assign illegal_s = (op_s >= OP_ILL_MIN);

  // Illegal-opcode flag, tracking the ID/EX slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_illegal_r <= 1'b0;
    end else if (bubble_s) begin
      ex_illegal_r <= 1'b0;
    end else if (!stall) begin
      ex_illegal_r <= illegal_s;
    end
  end

  assign ex_illegal = ex_illegal_r;
`endif

  // ID/EX pipeline register: flush/hazard/invalid load a zeroed bubble,
  // stall holds, otherwise the decoded instruction is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0;
      ex_pc_r    <= '0;
      ex_rs_r    <= 3'd0;
      ex_rt_r    <= 3'd0;
      ex_dest_r  <= 3'd0;
      ex_imm_r   <= '0;
      ex_reg1_r  <= '0;
      ex_reg2_r  <= '0;
      ex_ctrl_r  <= '0;
    end else if (bubble_s) begin
      ex_valid_r <= 1'b0;
      ex_pc_r    <= '0;
      ex_rs_r    <= 3'd0;
      ex_rt_r    <= 3'd0;
      ex_dest_r  <= 3'd0;
      ex_imm_r   <= '0;
      ex_reg1_r  <= '0;
      ex_reg2_r  <= '0;
      ex_ctrl_r  <= '0;
    end else if (!stall) begin
      ex_valid_r <= 1'b1;
      ex_pc_r    <= pc;
      ex_rs_r    <= rs_s;
      ex_rt_r    <= rt_s;
      ex_dest_r  <= dest_s;
      ex_imm_r   <= imm_s;
      ex_reg1_r  <= rdata1_s;
      ex_reg2_r  <= rdata2_s;
      ex_ctrl_r  <= ctrl_s;
    end
  end

  assign hazard_stall  = hazard_s;
  assign ex_valid      = ex_valid_r;
  assign ex_pc         = ex_pc_r;
  assign ex_rs         = ex_rs_r;
  assign ex_rt         = ex_rt_r;
  assign ex_dest       = ex_dest_r;
  assign ex_imm        = ex_imm_r;
  assign ex_reg1_data  = ex_reg1_r;
  assign ex_reg2_data  = ex_reg2_r;
  assign ex_reg_write  = ex_ctrl_r.reg_write;
  assign ex_mem_read   = ex_ctrl_r.mem_read;
  assign ex_mem_write  = ex_ctrl_r.mem_write;
  assign ex_mem_to_reg = ex_ctrl_r.mem_to_reg;
  assign ex_alu_src    = ex_ctrl_r.alu_src;
  assign ex_alu_op     = ex_ctrl_r.alu_op;
  assign ex_branch     = ex_ctrl_r.branch;
  assign ex_branch_ne  = ex_ctrl_r.branch_ne;
  assign ex_jump       = ex_ctrl_r.jump;
  assign ex_jump_reg   = ex_ctrl_r.jump_reg;
  assign ex_link       = ex_ctrl_r.link;

endmodule

// File: tb/tb_id_stage_p.sv
// Self-checking bench for id_stage_p (XLEN=32, bypass and hazard detection on).
// A table-driven reference model predicts the ID/EX contents and hazard_stall
// every cycle; directed sequences cover reset, bypass, immediates, load-use
// hazards, stall/flush interaction and JAL/illegal decode, followed by a
// randomized run.
module tb_id_stage_p;

  localparam int XLEN = 32;
  localparam int BYP  = 1;
  localparam int HAZ  = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall, flush, instr_valid;
  logic [15:0]     instruction;
  logic [XLEN-1:0] pc;
  logic            wb_reg_write;
  logic [2:0]      wb_write_reg;
  logic [XLEN-1:0] wb_write_data;
  logic            hazard_stall, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_reg1_data, ex_reg2_data;
  logic [2:0]      ex_rs, ex_rt, ex_dest;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]      ex_alu_op;
  logic            ex_branch, ex_branch_ne, ex_jump, ex_jump_reg, ex_link;
`ifdef ID_ILLEGAL_TRAP_EN
  logic            ex_illegal;
`endif

  id_stage_p #(.XLEN(XLEN), .WB_BYPASS(BYP), .HAZARD_DETECT(HAZ)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .instr_valid(instr_valid), .instruction(instruction), .pc(pc),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_imm(ex_imm), .ex_reg1_data(ex_reg1_data),
    .ex_reg2_data(ex_reg2_data), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
    .ex_jump(ex_jump), .ex_jump_reg(ex_jump_reg), .ex_link(ex_link)
`ifdef ID_ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state. ctrl = {rw,mr,mw,m2r,as,alu_op[3:0],br,bne,j,jr,link}
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [2:0]      rs, rt, dest;
    logic [XLEN-1:0] imm, d1, d2;
    logic [13:0]     ctrl;
    logic            illegal;
  } ex_m_t;

  ex_m_t           m_ex;
  logic [XLEN-1:0] m_rf [8];
  logic [9:0]      flags_tab [16];  // {rw,mr,mw,m2r,as,br,bne,j,jr,link}
  logic [3:0]      alu_tab   [16];
  int              dest_tab  [16];  // 0 none, 1 rd, 2 rt, 3 link register
  logic            zext_tab  [16];
  int              chk_cnt = 0;
  int              err_cnt = 0;
  logic            last_haz;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic init_tables();
    for (int i = 0; i < 16; i++) begin
      flags_tab[i] = 10'b0; alu_tab[i] = 4'h0; dest_tab[i] = 0; zext_tab[i] = 1'b0;
    end
    flags_tab[0]  = 10'b10000_00000; dest_tab[0]  = 1;
    flags_tab[1]  = 10'b10001_00000; dest_tab[1]  = 2; alu_tab[1]  = 4'h0;
    flags_tab[2]  = 10'b11011_00000; dest_tab[2]  = 2; alu_tab[2]  = 4'h0;
    flags_tab[3]  = 10'b00101_00000;                   alu_tab[3]  = 4'h0;
    flags_tab[4]  = 10'b00000_10000;                   alu_tab[4]  = 4'h1;
    flags_tab[5]  = 10'b00000_01000;                   alu_tab[5]  = 4'h1;
    flags_tab[6]  = 10'b00000_00100;
    flags_tab[7]  = 10'b10000_00101; dest_tab[7]  = 3;
    flags_tab[8]  = 10'b00000_00010;
    flags_tab[9]  = 10'b10001_00000; dest_tab[9]  = 2; alu_tab[9]  = 4'h2; zext_tab[9]  = 1'b1;
    flags_tab[10] = 10'b10001_00000; dest_tab[10] = 2; alu_tab[10] = 4'h3; zext_tab[10] = 1'b1;
    flags_tab[11] = 10'b10001_00000; dest_tab[11] = 2; alu_tab[11] = 4'h5;
  endtask

  function automatic logic [XLEN-1:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return '0;
    if (BYP != 0 && wb_reg_write && wb_write_reg == a) return wb_write_data;
    return m_rf[a];
  endfunction

  function automatic ex_m_t m_decode();
    ex_m_t d;
    int op;
    logic [5:0] imm6;
    op = int'(instruction[15:12]);
    imm6 = instruction[5:0];
    d = '0;
    d.valid = 1'b1;
    d.pc = pc;
    d.rs = instruction[11:9];
    d.rt = instruction[8:6];
    d.imm = zext_tab[op] ? XLEN'(imm6) : XLEN'($signed(imm6));
    d.d1 = m_read(d.rs);
    d.d2 = m_read(d.rt);
    case (dest_tab[op])
      1:       d.dest = instruction[5:3];
      2:       d.dest = instruction[8:6];
      3:       d.dest = 3'd7;
      default: d.dest = 3'd0;
    endcase
    d.ctrl = {flags_tab[op][9:5], (op == 0) ? {1'b0, instruction[2:0]} : alu_tab[op],
              flags_tab[op][4:0]};
    d.illegal = (op >= 12);
    return d;
  endfunction

  function automatic logic m_hazard();
    int op;
    logic use_rs, use_rt;
    op = int'(instruction[15:12]);
    use_rs = (op <= 11) && (op != 6) && (op != 7);
    use_rt = (op == 0) || (op == 3) || (op == 4) || (op == 5);
    return (HAZ != 0) && instr_valid && m_ex.valid && m_ex.ctrl[12] && (m_ex.dest != 3'd0) &&
           ((use_rs && instruction[11:9] == m_ex.dest) || (use_rt && instruction[8:6] == m_ex.dest));
  endfunction

  task automatic model_reset();
    m_ex = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
  endtask

  task automatic check_ex();
    check_eq("ex_valid", 64'(ex_valid), 64'(m_ex.valid));
    check_eq("ex_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
             ex_alu_op, ex_branch, ex_branch_ne, ex_jump, ex_jump_reg, ex_link}), 64'(m_ex.ctrl));
    check_eq("ex_pc", 64'(ex_pc), 64'(m_ex.pc));
    check_eq("ex_regs", 64'({ex_rs, ex_rt, ex_dest}), 64'({m_ex.rs, m_ex.rt, m_ex.dest}));
    check_eq("ex_imm", 64'(ex_imm), 64'(m_ex.imm));
    check_eq("ex_reg1_data", 64'(ex_reg1_data), 64'(m_ex.d1));
    check_eq("ex_reg2_data", 64'(ex_reg2_data), 64'(m_ex.d2));
`ifdef ID_ILLEGAL_TRAP_EN
    check_eq("ex_illegal", 64'(ex_illegal), 64'(m_ex.illegal));
`endif
  endtask

  // One clock: drive at negedge, check hazard_stall, advance model, check ID/EX
  task automatic cycle(input logic stl, input logic fl, input logic iv, input logic [15:0] ins,
                       input logic [XLEN-1:0] p, input logic we, input logic [2:0] wr,
                       input logic [XLEN-1:0] wd);
    logic h;
    @(negedge clk);
    stall = stl; flush = fl; instr_valid = iv; instruction = ins; pc = p;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    #1;
    h = m_hazard();
    last_haz = hazard_stall;
    check_eq("hazard_stall", 64'(hazard_stall), 64'(h));
    if (fl) m_ex = '0;
    else if (stl) m_ex = m_ex;
    else if (h || !iv) m_ex = '0;
    else m_ex = m_decode();
    if (we && wr != 3'd0) m_rf[wr] = wd;
    @(posedge clk);
    #1;
    check_ex();
  endtask

  // Asynchronous reset pulse away from the clock edge, released at a negedge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_ex();
    check_eq("rst_hazard", 64'(hazard_stall), 64'(0));
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; instr_valid = 1'b0; wb_reg_write = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] ins;
    int haz_cycles;
    init_tables();
    model_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; instr_valid = 1'b0;
    instruction = 16'h0; pc = '0; wb_reg_write = 1'b0; wb_write_reg = 3'd0; wb_write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_ex();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill registers, load LW, reset mid-run, confirm clear
    for (int i = 1; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, '0, 1'b1, 3'(i), 32'h1111_0000 + 32'(i));
    cycle(1'b0, 1'b0, 1'b1, 16'h2508, 32'h100, 1'b0, 3'd0, '0);
    check_eq("lw_mem_read", 64'(ex_mem_read), 64'(1));
    do_reset();
    check_eq("rst_mem_read", 64'(ex_mem_read), 64'(0));
    for (int i = 1; i < 8; i++) begin
      ins = {4'h0, 3'(i), 3'(i), 3'd1, 3'd0};
      cycle(1'b0, 1'b0, 1'b1, ins, 32'h200, 1'b0, 3'd0, '0);
      check_eq("rf_clear", 64'(ex_reg1_data), 64'(0));
    end

    // Writeback bypass into same-cycle decode
    cycle(1'b0, 1'b0, 1'b1, 16'h0250, 32'h300, 1'b1, 3'd1, 32'hABCD);
    check_eq("bypass_rs", 64'(ex_reg1_data), 64'((BYP != 0) ? 32'hABCD : 32'h0));
    check_eq("bypass_rt", 64'(ex_reg2_data), 64'((BYP != 0) ? 32'hABCD : 32'h0));

    // Immediate extension
    cycle(1'b0, 1'b0, 1'b1, 16'h12FB, 32'h304, 1'b0, 3'd0, '0);
    check_eq("addi_imm", 64'(ex_imm), 64'(32'hFFFF_FFFB));
    check_eq("addi_src", 64'({ex_alu_src, ex_dest}), 64'({1'b1, 3'd3}));
    cycle(1'b0, 1'b0, 1'b1, 16'hA2FB, 32'h308, 1'b0, 3'd0, '0);
    check_eq("ori_imm", 64'(ex_imm), 64'(32'h0000_003B));

    // Load-use: LW r4 then ADD r5,r4,r3
    cycle(1'b0, 1'b0, 1'b1, 16'h2508, 32'h400, 1'b0, 3'd0, '0);
    haz_cycles = 0;
    cycle(1'b0, 1'b0, 1'b1, 16'h08E8, 32'h404, 1'b0, 3'd0, '0);
    haz_cycles += int'(last_haz);
    check_eq("lu_bubble", 64'(ex_valid), 64'(0));
    cycle(1'b0, 1'b0, 1'b1, 16'h08E8, 32'h404, 1'b0, 3'd0, '0);
    haz_cycles += int'(last_haz);
    check_eq("lu_haz_cycles", 64'(haz_cycles), 64'(1));
    check_eq("lu_add_rs", 64'({ex_valid, ex_rs}), 64'({1'b1, 3'd4}));

    // LW r4 then SW r4 under a 3-cycle external stall
    cycle(1'b0, 1'b0, 1'b1, 16'h2508, 32'h500, 1'b0, 3'd0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 16'h3100, 32'h504, 1'b0, 3'd0, '0);
      check_eq("stall_haz", 64'(last_haz), 64'(1));
      check_eq("stall_hold", 64'({ex_valid, ex_mem_read, ex_pc}), 64'({1'b1, 1'b1, 32'h500}));
    end
    cycle(1'b0, 1'b0, 1'b1, 16'h3100, 32'h504, 1'b0, 3'd0, '0);
    check_eq("stall_bubble", 64'(ex_valid), 64'(0));
    cycle(1'b0, 1'b0, 1'b1, 16'h3100, 32'h504, 1'b0, 3'd0, '0);
    check_eq("sw_after", 64'({ex_valid, ex_mem_write}), 64'({1'b1, 1'b1}));

    // Flush beats stall; JAL; illegal opcode
    cycle(1'b1, 1'b1, 1'b1, 16'h7000, 32'h600, 1'b0, 3'd0, '0);
    check_eq("flush_jal", 64'(ex_valid), 64'(0));
    cycle(1'b0, 1'b0, 1'b1, 16'h7000, 32'h604, 1'b0, 3'd0, '0);
    check_eq("jal_ctrl", 64'({ex_link, ex_dest, ex_reg_write}), 64'({1'b1, 3'd7, 1'b1}));
    cycle(1'b0, 1'b0, 1'b1, 16'hD000, 32'h608, 1'b0, 3'd0, '0);
    check_eq("illegal_valid", 64'(ex_valid), 64'(1));
`ifdef ID_ILLEGAL_TRAP_EN
    check_eq("illegal_flag", 64'(ex_illegal), 64'(1));
`endif

    // Randomized run
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'h2;
      if ($urandom_range(0, 1) == 1) ins[11:9] = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) ins[8:6] = 3'($urandom_range(0, 4));
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 9) != 0), ins, XLEN'($urandom),
            ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), XLEN'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
